// File: rtl/intr_call_seq.sv
// Control-flow sequencer for CALL / RET / RETI and interrupt entry.
// Drives stack push/pop strobes, PC source selects and the global interrupt enable.
module intr_call_seq #(
    parameter int PC_W         = 32,
    parameter int WORD_W       = 16,
    parameter int DRAIN_CYCLES = 5,
    parameter int RET_LATENCY  = 2,
    parameter int NUM_IRQ      = 4,
    parameter int IDXW         = ((PC_W / WORD_W) > 1) ? $clog2(PC_W / WORD_W) : 1,
    parameter int VIDW         = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               op_valid,
    input  logic [1:0]         op_code,
    output logic               op_ready,
    input  logic [NUM_IRQ-1:0] irq_req,
    output logic [NUM_IRQ-1:0] irq_ack,
    output logic               busy,
    output logic               stall_fetch,
    output logic               insert_nop,
    output logic               mem_push,
    output logic               mem_pop,
    output logic               push_sel,
    output logic [IDXW-1:0]    word_idx,
    output logic               flag_restore,
    output logic               pc_load_target,
    output logic               pc_load_mem,
    output logic               pc_load_vector,
    output logic [VIDW-1:0]    vector_id,
    output logic               int_enable
);

    localparam int NWORDS = PC_W / WORD_W;
    localparam int MAX_AB = (DRAIN_CYCLES > NWORDS) ? DRAIN_CYCLES : NWORDS;
    localparam int MAXC   = (MAX_AB > RET_LATENCY) ? MAX_AB : RET_LATENCY;
    localparam int CNT_W  = $clog2(MAXC + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_DRAIN, S_PUSH_PC, S_PUSH_FLAGS, S_VECTOR,
        S_CALL_PUSH, S_POP_FLAGS, S_POP_PC, S_RET_WAIT
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [VIDW-1:0]  r_vector_id, w_vid_nxt;
    logic             r_int_enable, w_ie_nxt;
    logic             r_is_reti, w_reti_nxt;
    logic [VIDW-1:0]  w_irq_idx;
    logic             w_irq_take;
    logic             w_words_last;

    // Lowest set request index wins.
    always_comb begin
        w_irq_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (irq_req[i]) w_irq_idx = VIDW'(i);
        end
    end

    assign w_irq_take   = (r_state == S_IDLE) && r_int_enable && (|irq_req) && !reset;
    assign w_words_last = (r_cnt == CNT_W'(NWORDS - 1));

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_vid_nxt      = r_vector_id;
        w_ie_nxt       = r_int_enable;
        w_reti_nxt     = r_is_reti;
        op_ready       = 1'b0;
        irq_ack        = '0;
        insert_nop     = 1'b0;
        mem_push       = 1'b0;
        mem_pop        = 1'b0;
        push_sel       = 1'b0;
        word_idx       = '0;
        flag_restore   = 1'b0;
        pc_load_target = 1'b0;
        pc_load_mem    = 1'b0;
        pc_load_vector = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                op_ready  = !w_irq_take && !reset;
                if (w_irq_take) begin
                    irq_ack     = NUM_IRQ'(1) << w_irq_idx;
                    w_vid_nxt   = w_irq_idx;
                    w_ie_nxt    = 1'b0;
                    w_state_nxt = S_DRAIN;
                end else if (op_valid) begin
                    case (op_code)
                        2'b01: w_state_nxt = S_CALL_PUSH;
                        2'b10: begin w_state_nxt = S_POP_PC;    w_reti_nxt = 1'b0; end
                        2'b11: begin w_state_nxt = S_POP_FLAGS; w_reti_nxt = 1'b1; end
                        default: w_state_nxt = S_IDLE;
                    endcase
                end
            end
            S_DRAIN: begin
                insert_nop = 1'b1;
                if (r_cnt == CNT_W'(DRAIN_CYCLES - 1)) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_PUSH_PC;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_PUSH_PC, S_CALL_PUSH: begin
                // High word goes first so the pop order comes back low-to-high.
                mem_push = 1'b1;
                word_idx = IDXW'(NWORDS - 1) - r_cnt[IDXW-1:0];
                if (w_words_last) begin
                    w_cnt_nxt      = '0;
                    pc_load_target = (r_state == S_CALL_PUSH);
                    w_state_nxt    = (r_state == S_CALL_PUSH) ? S_IDLE : S_PUSH_FLAGS;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_PUSH_FLAGS: begin
                mem_push    = 1'b1;
                push_sel    = 1'b1;
                w_state_nxt = S_VECTOR;
            end
            S_VECTOR: begin
                pc_load_vector = 1'b1;
                w_state_nxt    = S_IDLE;
            end
            S_POP_FLAGS: begin
                mem_pop      = 1'b1;
                flag_restore = 1'b1;
                w_cnt_nxt    = '0;
                w_state_nxt  = S_POP_PC;
            end
            S_POP_PC: begin
                mem_pop  = 1'b1;
                word_idx = r_cnt[IDXW-1:0];
                if (w_words_last) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_RET_WAIT;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_RET_WAIT: begin
                if (r_cnt == CNT_W'(RET_LATENCY - 1)) begin
                    pc_load_mem = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                    if (r_is_reti) w_ie_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_vector_id  <= '0;
            r_int_enable <= 1'b1;
            r_is_reti    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_vector_id  <= w_vid_nxt;
            r_int_enable <= w_ie_nxt;
            r_is_reti    <= w_reti_nxt;
        end
    end

    assign busy        = (r_state != S_IDLE);
    assign stall_fetch = busy;
    assign vector_id   = r_vector_id;
    assign int_enable  = r_int_enable;

endmodule

// File: tb/tb_intr_call_seq.sv
// Directed bench for intr_call_seq at default parameters (2 PC words, 4 IRQs).
// Inputs change just after the rising edge; outputs are checked at the falling edge.
module tb_intr_call_seq;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       op_valid = 1'b0;
    logic [1:0] op_code = 2'b00;
    logic [3:0] irq_req = 4'b0000;
    logic       op_ready, busy, stall_fetch, insert_nop, mem_push, mem_pop, push_sel;
    logic       flag_restore, pc_load_target, pc_load_mem, pc_load_vector, int_enable;
    logic [3:0] irq_ack;
    logic [0:0] word_idx;
    logic [1:0] vector_id;

    int total = 0;
    int bad   = 0;

    localparam logic [9:0] NOP  = 10'b10_0000_0000;
    localparam logic [9:0] PSH  = 10'b01_0000_0000;
    localparam logic [9:0] POP  = 10'b00_1000_0000;
    localparam logic [9:0] SEL  = 10'b00_0100_0000;
    localparam logic [9:0] FRS  = 10'b00_0010_0000;
    localparam logic [9:0] PLT  = 10'b00_0001_0000;
    localparam logic [9:0] PLM  = 10'b00_0000_1000;
    localparam logic [9:0] PLV  = 10'b00_0000_0100;
    localparam logic [9:0] BSY  = 10'b00_0000_0011;

    intr_call_seq dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op_code(op_code),
        .op_ready(op_ready), .irq_req(irq_req), .irq_ack(irq_ack),
        .busy(busy), .stall_fetch(stall_fetch), .insert_nop(insert_nop),
        .mem_push(mem_push), .mem_pop(mem_pop), .push_sel(push_sel),
        .word_idx(word_idx), .flag_restore(flag_restore),
        .pc_load_target(pc_load_target), .pc_load_mem(pc_load_mem),
        .pc_load_vector(pc_load_vector), .vector_id(vector_id),
        .int_enable(int_enable)
    );

    always #5 clk = ~clk;

    wire [9:0] w_strb = {insert_nop, mem_push, mem_pop, push_sel, flag_restore,
                         pc_load_target, pc_load_mem, pc_load_vector, busy, stall_fetch};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    // Check one cycle at the falling edge, then advance to just after the next rising edge.
    task automatic step(input string tag, input logic [9:0] s, input logic idx,
                        input logic [3:0] ack, input logic rdy, input logic ie);
        @(negedge clk);
        chk({tag, ".strb"}, 32'(w_strb), 32'(s));
        chk({tag, ".idx"},  32'(word_idx), 32'(idx));
        chk({tag, ".ack"},  32'(irq_ack), 32'(ack));
        chk({tag, ".rdy"},  32'(op_ready), 32'(rdy));
        chk({tag, ".ie"},   32'(int_enable), 32'(ie));
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        step("rst0", 10'd0, 1'b0, 4'b0, 1'b0, 1'b1);
        chk("rst0.vid", 32'(vector_id), 32'd0);
        reset = 1'b0;
        step("idle", 10'd0, 1'b0, 4'b0, 1'b1, 1'b1);

        // CALL
        op_valid = 1'b1; op_code = 2'b01;
        step("call0", 10'd0, 1'b0, 4'b0, 1'b1, 1'b1);
        op_valid = 1'b0;
        step("call1", PSH | BSY, 1'b1, 4'b0, 1'b0, 1'b1);
        step("call2", PSH | PLT | BSY, 1'b0, 4'b0, 1'b0, 1'b1);
        step("call3", 10'd0, 1'b0, 4'b0, 1'b1, 1'b1);

        // RET
        op_valid = 1'b1; op_code = 2'b10;
        step("ret0", 10'd0, 1'b0, 4'b0, 1'b1, 1'b1);
        op_valid = 1'b0;
        step("ret1", POP | BSY, 1'b0, 4'b0, 1'b0, 1'b1);
        step("ret2", POP | BSY, 1'b1, 4'b0, 1'b0, 1'b1);
        step("ret3", BSY, 1'b0, 4'b0, 1'b0, 1'b1);
        step("ret4", PLM | BSY, 1'b0, 4'b0, 1'b0, 1'b1);
        step("ret5", 10'd0, 1'b0, 4'b0, 1'b1, 1'b1);

        // Interrupt entry, request held high throughout
        irq_req = 4'b0110;
        step("irq0", 10'd0, 1'b0, 4'b0010, 1'b0, 1'b1);
        for (int i = 1; i <= 5; i++) step("irqdrain", NOP | BSY, 1'b0, 4'b0, 1'b0, 1'b0);
        step("irq6", PSH | BSY, 1'b1, 4'b0, 1'b0, 1'b0);
        step("irq7", PSH | BSY, 1'b0, 4'b0, 1'b0, 1'b0);
        step("irq8", PSH | SEL | BSY, 1'b0, 4'b0, 1'b0, 1'b0);
        step("irq9", PLV | BSY, 1'b0, 4'b0, 1'b0, 1'b0);
        chk("irq9.vid", 32'(vector_id), 32'd1);
        step("irq10", 10'd0, 1'b0, 4'b0, 1'b1, 1'b0);
        irq_req = 4'b0000;

        // RETI
        op_valid = 1'b1; op_code = 2'b11;
        step("reti0", 10'd0, 1'b0, 4'b0, 1'b1, 1'b0);
        op_valid = 1'b0;
        step("reti1", POP | FRS | BSY, 1'b0, 4'b0, 1'b0, 1'b0);
        step("reti2", POP | BSY, 1'b0, 4'b0, 1'b0, 1'b0);
        step("reti3", POP | BSY, 1'b1, 4'b0, 1'b0, 1'b0);
        step("reti4", BSY, 1'b0, 4'b0, 1'b0, 1'b0);
        step("reti5", PLM | BSY, 1'b0, 4'b0, 1'b0, 1'b0);
        step("reti6", 10'd0, 1'b0, 4'b0, 1'b1, 1'b1);

        // Reset during DRAIN, request retaken afterwards
        irq_req = 4'b0100;
        step("rd0", 10'd0, 1'b0, 4'b0100, 1'b0, 1'b1);
        step("rd1", NOP | BSY, 1'b0, 4'b0, 1'b0, 1'b0);
        step("rd2", NOP | BSY, 1'b0, 4'b0, 1'b0, 1'b0);
        reset = 1'b1;
        step("rd3", 10'd0, 1'b0, 4'b0, 1'b0, 1'b1);
        chk("rd3.vid", 32'(vector_id), 32'd0);
        step("rd4", 10'd0, 1'b0, 4'b0, 1'b0, 1'b1);
        reset = 1'b0;
        step("rd5", 10'd0, 1'b0, 4'b0100, 1'b0, 1'b1);
        step("rd6", NOP | BSY, 1'b0, 4'b0, 1'b0, 1'b0);
        chk("rd6.vid", 32'(vector_id), 32'd2);
        irq_req = 4'b0000;
        reset = 1'b1;
        step("rd7", 10'd0, 1'b0, 4'b0, 1'b0, 1'b1);
        reset = 1'b0;

        // Interrupt beats a simultaneous CALL; CALL goes through afterwards
        irq_req = 4'b0001; op_valid = 1'b1; op_code = 2'b01;
        step("pri0", 10'd0, 1'b0, 4'b0001, 1'b0, 1'b1);
        irq_req = 4'b0000;
        for (int i = 1; i <= 5; i++) step("pridrain", NOP | BSY, 1'b0, 4'b0, 1'b0, 1'b0);
        step("pri6", PSH | BSY, 1'b1, 4'b0, 1'b0, 1'b0);
        step("pri7", PSH | BSY, 1'b0, 4'b0, 1'b0, 1'b0);
        step("pri8", PSH | SEL | BSY, 1'b0, 4'b0, 1'b0, 1'b0);
        step("pri9", PLV | BSY, 1'b0, 4'b0, 1'b0, 1'b0);
        chk("pri9.vid", 32'(vector_id), 32'd0);
        step("pri10", 10'd0, 1'b0, 4'b0, 1'b1, 1'b0);
        op_valid = 1'b0;
        step("pri11", PSH | BSY, 1'b1, 4'b0, 1'b0, 1'b0);
        step("pri12", PSH | PLT | BSY, 1'b0, 4'b0, 1'b0, 1'b0);
        step("pri13", 10'd0, 1'b0, 4'b0, 1'b1, 1'b0);

        // op_code 00 is accepted with no effect
        op_valid = 1'b1; op_code = 2'b00;
        step("nop0", 10'd0, 1'b0, 4'b0, 1'b1, 1'b0);
        op_valid = 1'b0;
        step("nop1", 10'd0, 1'b0, 4'b0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/intr_call_seq.md
INTR_CALL_SEQ -- requirements
Module: intr_call_seq

Parameters
REQ-001 PC_W, 32, program-counter width in bits.
REQ-002 WORD_W, 16, stack word width; PC_W SHALL be a multiple of WORD_W; NWORDS = PC_W/WORD_W, at least 1.
REQ-003 DRAIN_CYCLES, 5, NOP-insertion cycles before interrupt entry; at least 1.
REQ-004 RET_LATENCY, 2, cycles from last PC pop to PC load; at least 1.
REQ-005 NUM_IRQ, 4, interrupt source count; at least 1.
REQ-006 IDXW = max(1,clog2(NWORDS)); VIDW = max(1,clog2(NUM_IRQ)).

Interface
REQ-007 clk  in  1  single clock; all state updates on its rising edge.
REQ-008 reset  in  1  asynchronous, active-high reset.
REQ-009 op_valid  in  1  decode presents a control op.
REQ-010 op_code  in  2  00 none, 01 CALL, 10 RET, 11 RETI.
REQ-011 op_ready  out  1  op accepted this cycle when op_valid and op_ready are both high.
REQ-012 irq_req  in  NUM_IRQ  level interrupt requests; bit 0 has highest priority.
REQ-013 irq_ack  out  NUM_IRQ  one-hot pulse marking the source taken.
REQ-014 busy, stall_fetch  out  1 each  sequence in progress / freeze fetch.
REQ-015 insert_nop  out  1  replace the decode-stage instruction with a NOP.
REQ-016 mem_push, mem_pop  out  1 each  stack push / pop strobes.
REQ-017 push_sel  out  1  0 = PC word, 1 = flags.
REQ-018 word_idx  out  IDXW  PC word being pushed or popped.
REQ-019 flag_restore  out  1  load the flag register from popped data.
REQ-020 pc_load_target, pc_load_mem, pc_load_vector  out  1 each  PC source strobes.
REQ-021 vector_id  out  VIDW  latched interrupt source index.
REQ-022 int_enable  out  1  global interrupt enable.

Function
REQ-023 States: IDLE, DRAIN, PUSH_PC, PUSH_FLAGS, VECTOR, CALL_PUSH, POP_FLAGS, POP_PC, RET_WAIT; one shared cycle counter.
REQ-024 busy = stall_fetch = (state != IDLE); op_ready = IDLE and no interrupt taken this cycle.
REQ-025 Interrupt taken: in IDLE with int_enable=1 and any irq_req bit set; irq_ack pulses the lowest set index in the same cycle; vector_id latches that index; int_enable clears next edge; next state DRAIN.
REQ-026 Simultaneous interrupt and op_valid in IDLE: the interrupt wins; op_ready=0; the op is held by decode.
REQ-027 DRAIN: DRAIN_CYCLES cycles, insert_nop=1 in each; then PUSH_PC.
REQ-028 PUSH_PC: NWORDS cycles, mem_push=1, push_sel=0, word_idx descending NWORDS-1..0; then PUSH_FLAGS.
REQ-029 PUSH_FLAGS: 1 cycle, mem_push=1, push_sel=1; then VECTOR.
REQ-030 VECTOR: 1 cycle, pc_load_vector=1; then IDLE.
REQ-031 CALL accepted: CALL_PUSH for NWORDS cycles, mem_push=1, push_sel=0, word_idx descending; pc_load_target=1 on the final cycle; then IDLE.
REQ-032 RET accepted: POP_PC for NWORDS cycles, mem_pop=1, word_idx ascending 0..NWORDS-1; then RET_WAIT for RET_LATENCY cycles; pc_load_mem=1 on its final cycle; then IDLE.
REQ-033 RETI accepted: POP_FLAGS for 1 cycle (mem_pop=1, flag_restore=1); then the RET sequence; int_enable sets on the edge leaving RET_WAIT.
REQ-034 op_code 00 with op_valid: accepted, no action, state stays IDLE.
REQ-035 irq_req changes while busy are ignored; a still-asserted request is taken on the first IDLE cycle with int_enable=1.
REQ-036 Every strobe not named for the current state/cycle SHALL be 0; strobes are functions of registered state and counter only, except irq_ack and op_ready.

Reset
REQ-037 Reset asserted at any time, including mid-sequence, forces IDLE, counter 0, vector_id 0, int_enable 1, and all strobes, busy and stall_fetch 0; in-flight sequences are abandoned.

Verification (defaults; op or irq presented in cycle 0)
REQ-038 CALL -> mem_push with word_idx 1,0 in cycles 1-2; pc_load_target in cycle 2; busy=0 in cycle 3.
REQ-039 RET -> mem_pop with word_idx 0,1 in cycles 1-2; stall in cycles 3-4; pc_load_mem in cycle 4; IDLE in cycle 5.
REQ-040 irq_req=0110 -> irq_ack=0010 in cycle 0; insert_nop in cycles 1-5; PC pushes in cycles 6-7; flags push in cycle 8; pc_load_vector with vector_id=1 in cycle 9; int_enable=0 from cycle 1.
REQ-041 RETI after REQ-040 -> flag_restore in cycle 1; pops in cycles 2-3; pc_load_mem in cycle 5; int_enable=1 in cycle 6.
REQ-042 irq_req=0001 together with CALL -> irq_ack=0001, op_ready=0, DRAIN entered; CALL accepted after return to IDLE.
REQ-043 reset in cycle 3 of DRAIN -> next cycle IDLE, all outputs 0, int_enable=1; an asserted irq is retaken after reset deasserts.
